// File: rtl/demux32_1to4_dispatch_if.sv
// ---------------------------------------------------------------------------
// demux32_1to4_dispatch_if
// Bundle of the upstream handshake, the four downstream lanes and the debug
// lane counters of the 1-to-4 dispatcher.
//   in_data/in_sel/in_valid : upstream word, destination lane, word present
//   in_ready                : dispatcher accepts this cycle
//   out_data0..3            : per-lane held word
//   out_valid[i]            : lane i holds a word
//   out_ready[i]            : lane i consumer takes the word
//   lane_count              : lane i accepted-word count at [i*CNT_W +: CNT_W]
// Modports: slave = dispatcher side, master = producer/consumer side.
// ---------------------------------------------------------------------------
interface demux32_1to4_dispatch_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
);
  logic [DATA_W-1:0]  in_data;
  logic [1:0]         in_sel;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  out_data0;
  logic [DATA_W-1:0]  out_data1;
  logic [DATA_W-1:0]  out_data2;
  logic [DATA_W-1:0]  out_data3;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [4*CNT_W-1:0] lane_count;

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data0, out_data1, out_data2, out_data3,
           out_valid, lane_count
  );

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data0, out_data1, out_data2, out_data3,
           out_valid, lane_count
  );
endinterface

// File: rtl/demux32_1to4_dispatch.sv
// ---------------------------------------------------------------------------
// demux32_1to4_dispatch
// Registered 1-to-4 dispatcher. One upstream word is steered to the lane named
// by in_sel; every lane owns a one-entry holding register and a wrapping
// accepted-word counter for debug.
// Ports:
//   Clk      : clock, rising edge
//   Reset_n  : asynchronous active-low reset
//   bus      : demux32_1to4_dispatch_if.slave (handshakes, lanes, counters)
// ---------------------------------------------------------------------------
module demux32_1to4_dispatch #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic Clk,
  input  logic Reset_n,
  demux32_1to4_dispatch_if.slave bus
);

  logic [3:0]        valid_r;
  logic [DATA_W-1:0] data_r [4];
  logic [CNT_W-1:0]  cnt_r  [4];

  logic [1:0] sel_s;
  logic       in_ready_s;
  logic       fire_s;
  logic [3:0] load_s;
  logic [3:0] drain_s;

  // Accept decision: only the selected lane matters, so a full neighbour
  // never stalls a transfer; held low during reset.
  always_comb begin
    sel_s      = bus.in_sel;
    in_ready_s = Reset_n & (~valid_r[sel_s] | bus.out_ready[sel_s]);
    fire_s     = bus.in_valid & in_ready_s;
    drain_s    = valid_r & bus.out_ready;
    load_s     = 4'b0000;
    if (fire_s) begin
      load_s[sel_s] = 1'b1;
    end else begin
      load_s = 4'b0000;
    end
  end

  // Lane registers: a load wins over a drain of the same lane, so a lane
  // streaming with out_ready high stays valid and takes a word every cycle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      valid_r <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        data_r[i] <= {DATA_W{1'b0}};
        cnt_r[i]  <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (load_s[i]) begin
          data_r[i]  <= bus.in_data;
          valid_r[i] <= 1'b1;
          cnt_r[i]   <= cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (drain_s[i]) begin
          valid_r[i] <= 1'b0;
        end else begin
          valid_r[i] <= valid_r[i];
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = valid_r;
  assign bus.out_data0 = data_r[0];
  assign bus.out_data1 = data_r[1];
  assign bus.out_data2 = data_r[2];
  assign bus.out_data3 = data_r[3];

  for (genvar g = 0; g < 4; g++) begin : g_cnt
    assign bus.lane_count[g*CNT_W +: CNT_W] = cnt_r[g];
  end

endmodule

// File: tb/tb_demux32_1to4_dispatch.sv
module tb_demux32_1to4_dispatch;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 1'b0;

  demux32_1to4_dispatch_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus();

  demux32_1to4_dispatch #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .Clk    (clk),
    .Reset_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per-lane "holding a word" flag, held word, and count.
  bit          m_valid [4];
  logic [31:0] m_data  [4];
  int          m_cnt   [4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_data(input int i);
    case (i)
      0: return bus.out_data0;
      1: return bus.out_data1;
      2: return bus.out_data2;
      default: return bus.out_data3;
    endcase
  endfunction

  function automatic bit model_ready();
    int s;
    s = int'(bus.in_sel);
    return rst_n && (!m_valid[s] || bus.out_ready[s]);
  endfunction

  // Model update: word accepted if the chosen lane is empty or being taken.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_valid[i] = 1'b0; m_data[i] = 32'd0; m_cnt[i] = 0;
      end
    end else begin
      int  s;
      bit  fire;
      s    = int'(bus.in_sel);
      fire = bus.in_valid && model_ready();
      for (int i = 0; i < 4; i++) begin
        if (fire && i == s) begin
          m_valid[i] = 1'b1;
          m_data[i]  = bus.in_data;
          m_cnt[i]   = (m_cnt[i] + 1) % (1 << CNT_W);
        end else if (m_valid[i] && bus.out_ready[i]) begin
          m_valid[i] = 1'b0;
        end
      end
    end
  end

  // Compare every cycle on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [3:0] ev;
      for (int i = 0; i < 4; i++) ev[i] = m_valid[i];
      chk("cyc_out_valid", 64'(bus.out_valid), 64'(ev));
      chk("cyc_in_ready", 64'(bus.in_ready), 64'(model_ready()));
      for (int i = 0; i < 4; i++) begin
        chk("cyc_out_data", 64'(dut_data(i)), 64'(m_data[i]));
        chk("cyc_lane_count", 64'(bus.lane_count[i*CNT_W +: CNT_W]), 64'(m_cnt[i]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s, input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.in_sel   = s;
    bus.in_data  = d;
  endtask

  // Mid-cycle reset with immediate (edge-free) checks.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_lane_count", 64'(bus.lane_count), 64'h0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'h0);
    chk("rst_out_data3", 64'(bus.out_data3), 64'h0);
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sel    = 2'd0;
    bus.in_data   = 32'd0;
    bus.out_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0; m_data[i] = 32'd0; m_cnt[i] = 0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("init_out_valid", 64'(bus.out_valid), 64'h0);
    chk("init_in_ready", 64'(bus.in_ready), 64'h0);
    chk_en = 1'b1;
    step(); step();
    rst_n = 1'b1;
    step();

    // Basic transfer to lane 2.
    bus.out_ready = 4'hF;
    send(2'd2, 32'hDEADBEEF);
    step();
    bus.in_valid = 1'b0;
    chk("basic_valid", 64'(bus.out_valid), 64'h4);
    chk("basic_data2", 64'(bus.out_data2), 64'hDEADBEEF);
    chk("basic_count2", 64'(bus.lane_count[2*CNT_W +: CNT_W]), 64'd1);
    step();
    chk("basic_clear", 64'(bus.out_valid), 64'h0);

    // Backpressure on lane 1.
    bus.out_ready = 4'b1101;
    send(2'd1, 32'hA0A0_0001);
    step();
    send(2'd1, 32'hB0B0_0002);
    #1;
    chk("bp_stall", 64'(bus.in_ready), 64'h0);
    step();
    chk("bp_hold_data", 64'(bus.out_data1), 64'hA0A0_0001);
    chk("bp_hold_valid", 64'(bus.out_valid), 64'h2);
    bus.out_ready = 4'hF;
    #1;
    chk("bp_release_ready", 64'(bus.in_ready), 64'h1);
    step();
    bus.in_valid = 1'b0;
    chk("bp_swap_data", 64'(bus.out_data1), 64'hB0B0_0002);
    chk("bp_swap_valid", 64'(bus.out_valid), 64'h2);
    step();

    // Lane independence: lane 0 stalled, lane 3 still accepts.
    bus.out_ready = 4'b1110;
    send(2'd0, 32'h0000_0001);
    step();
    send(2'd3, 32'h0000_0011);
    #1;
    chk("indep_ready", 64'(bus.in_ready), 64'h1);
    step();
    bus.in_valid = 1'b0;
    chk("indep_valid", 64'(bus.out_valid), 64'h9);
    chk("indep_data3", 64'(bus.out_data3), 64'h11);
    bus.out_ready = 4'hF;
    step();

    // Mid-run reset with lanes 1 and 3 full.
    bus.out_ready = 4'b0000;
    send(2'd1, 32'h1111_1111);
    step();
    send(2'd3, 32'h3333_3333);
    step();
    bus.in_valid = 1'b0;
    chk("pre_rst_valid", 64'(bus.out_valid), 64'hA);
    do_reset();

    // Streaming ten words into lane 0.
    bus.out_ready = 4'hF;
    for (int k = 0; k < 10; k++) begin
      send(2'd0, 32'h100 + 32'(k));
      #1;
      chk("stream_ready", 64'(bus.in_ready), 64'h1);
      step();
      chk("stream_data0", 64'(bus.out_data0), 64'(32'h100 + 32'(k)));
      chk("stream_valid0", 64'(bus.out_valid[0]), 64'h1);
    end
    bus.in_valid = 1'b0;
    chk("stream_count0", 64'(bus.lane_count[0 +: CNT_W]), 64'd10);
    step();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_sel    = 2'($urandom_range(0, 3));
      bus.in_data   = $urandom;
      bus.out_ready = 4'($urandom) | 4'($urandom);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'hF;
    step();

    // Counter wrap on lane 2.
    do_reset();
    bus.out_ready = 4'hF;
    for (int k = 0; k < 256; k++) begin
      send(2'd2, 32'(k));
      step();
      if (k == 254) chk("wrap_count_255", 64'(bus.lane_count[2*CNT_W +: CNT_W]), 64'd255);
    end
    bus.in_valid = 1'b0;
    chk("wrap_count2", 64'(bus.lane_count[2*CNT_W +: CNT_W]), 64'd0);
    chk("wrap_others", 64'({bus.lane_count[3*CNT_W +: CNT_W], bus.lane_count[CNT_W +: CNT_W],
                            bus.lane_count[0 +: CNT_W]}), 64'h0);
    chk("wrap_last_data", 64'(bus.out_data2), 64'd255);
    step(); step();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
